// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD seconds timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

// File: rtl/button_edge.sv
// Button conditioner: 2-flop synchronizer, optional debounce (TIMER_DEBOUNCE_EN),
// and rising-edge detector. The edge pulse is combinational from the flop chain.
module button_edge
`ifdef TIMER_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
)
`endif
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic level_prev_q;

  // Two-flop synchronizer for the raw asynchronous button level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync2_q == sync1_q ? sync1_q : sync1_q;
    end
  end

`ifdef TIMER_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             db_q;
  logic [CNT_W-1:0] cnt_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_edge: DEBOUNCE_CYCLES must be at least 1");
  end

  // Debounced level only follows sync2 once it has differed for a full window.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else if (sync2_q == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_q  <= sync2_q;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Previous debounced level for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= db_q;
    end
  end

  assign edge_o = db_q & ~level_prev_q;
`else
  // Third flop of the chain; sync2 & ~sync3 marks the rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= sync2_q;
    end
  end

  assign edge_o = sync2_q & ~level_prev_q;
`endif

endmodule

// File: rtl/bcd_timer_core.sv
// BCD seconds stopwatch core: IDLE/RUN/PAUSE control, 00..TENS_MAX9 count, carry pulse.
// Optional button debounce is enabled by defining TIMER_DEBOUNCE_EN.
module bcd_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned TENS_MAX        = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       StartStop,
  input  logic       Clear,
  output logic [3:0] Ones,
  output logic [3:0] Tens,
  output logic       Carry,
  output logic       Running
);

  localparam bcd_digit_t TENS_TOP = bcd_digit_t'(TENS_MAX);

  if (TENS_MAX < 1 || TENS_MAX > 9) begin : g_bad_tens
    $error("bcd_timer_core: TENS_MAX must be within 1..9");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("bcd_timer_core: DEBOUNCE_CYCLES must be at least 1");
  end

  timer_state_t state_q;
  bcd_digit_t   ones_q, tens_q;
  bcd_digit_t   ones_d, tens_d;
  logic         carry_q, carry_d;
  logic         running_q;
  logic         ss_edge_s, clr_edge_s;

`ifdef TIMER_DEBOUNCE_EN
  button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_edge (
`else
  button_edge u_ss_edge (
`endif
    .clk_i  (Clk),
    .rst_i  (Reset),
    .btn_i  (StartStop),
    .edge_o (ss_edge_s)
  );

`ifdef TIMER_DEBOUNCE_EN
  button_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_edge (
`else
  button_edge u_clr_edge (
`endif
    .clk_i  (Clk),
    .rst_i  (Reset),
    .btn_i  (Clear),
    .edge_o (clr_edge_s)
  );

  // Next count value if a tick is taken; wrap at TENS_MAX9 raises carry.
  always_comb begin
    ones_d  = ones_q;
    tens_d  = tens_q;
    carry_d = 1'b0;
    if (ones_q >= BCD_MAX) begin
      ones_d = 4'd0;
      if (tens_q >= TENS_TOP) begin
        tens_d  = 4'd0;
        carry_d = 1'b1;
      end else begin
        tens_d = tens_q + 4'd1;
      end
    end else begin
      ones_d = ones_q + 4'd1;
    end
  end

  // Control FSM and count registers. Clear outranks StartStop and Tick; in RUN a
  // coincident tick is counted before pausing, in PAUSE it is dropped.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else if (clr_edge_s) begin
      state_q   <= IDLE;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      carry_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ss_edge_s) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (Tick) begin
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            carry_q <= carry_d;
          end
          if (ss_edge_s) begin
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end
        PAUSE: begin
          if (ss_edge_s) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign Ones    = ones_q;
  assign Tens    = tens_q;
  assign Carry   = carry_q;
  assign Running = running_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
// Directed bench for bcd_timer_core: seconds-count model checked every cycle,
// plus hand-computed literal checkpoints for the listed scenarios.
module tb_bcd_timer_core;

  localparam int TMAX = 5;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b0;
  logic       StartStop = 1'b0;
  logic       Clear = 1'b0;
  logic [3:0] Ones, Tens;
  logic       Carry, Running;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model: seconds as a plain integer, mode 0=idle 1=run 2=pause
  int m_secs = 0;
  int m_mode = 0;
  bit m_carry = 1'b0;
  // button levels seen at the previous three edges ([0] most recent)
  bit ss_h [3];
  bit cl_h [3];

  bcd_timer_core #(.TENS_MAX(TMAX), .DEBOUNCE_CYCLES(250000)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Tick      (Tick),
    .StartStop (StartStop),
    .Clear     (Clear),
    .Ones      (Ones),
    .Tens      (Tens),
    .Carry     (Carry),
    .Running   (Running)
  );

  always #5 Clk = ~Clk;

  task automatic model_edge();
    bit ss_e, cl_e;
    // a press acts on the 3rd edge after the button rises
    ss_e = ss_h[1] && !ss_h[2];
    cl_e = cl_h[1] && !cl_h[2];
    if (Reset) begin
      m_secs = 0; m_mode = 0; m_carry = 1'b0;
      for (int i = 0; i < 3; i++) begin ss_h[i] = 1'b0; cl_h[i] = 1'b0; end
    end else begin
      if (cl_e) begin
        m_secs = 0; m_mode = 0; m_carry = 1'b0;
      end else begin
        m_carry = 1'b0;
        if (m_mode == 1 && Tick) begin
          if (m_secs == TMAX * 10 + 9) begin
            m_secs = 0; m_carry = 1'b1;
          end else begin
            m_secs = m_secs + 1;
          end
        end
        if (ss_e) m_mode = (m_mode == 1) ? 2 : 1;
      end
      ss_h[2] = ss_h[1]; ss_h[1] = ss_h[0]; ss_h[0] = StartStop;
      cl_h[2] = cl_h[1]; cl_h[1] = cl_h[0]; cl_h[0] = Clear;
    end
  endtask

  // one clock: update model from current inputs, then compare just after the edge
  task automatic step();
    int eo, et;
    model_edge();
    @(posedge Clk);
    #1;
    cyc++;
    eo = m_secs % 10;
    et = m_secs / 10;
    total++;
    if (Ones !== 4'(eo) || Tens !== 4'(et) || Carry !== m_carry || Running !== (m_mode == 1)) begin
      bad++;
      $display("FAIL cycle%0d: got tens=%0d ones=%0d carry=%b run=%b, want tens=%0d ones=%0d carry=%b run=%b",
               cyc, Tens, Ones, Carry, Running, et, eo, m_carry, (m_mode == 1));
    end
  endtask

  task automatic lit(input string name, input int et, input int eo, input bit ec, input bit er);
    total++;
    if (Tens !== 4'(et) || Ones !== 4'(eo) || Carry !== ec || Running !== er ||
        m_secs != et * 10 + eo || m_carry != ec || (m_mode == 1) != er) begin
      bad++;
      $display("FAIL %s: dut tens=%0d ones=%0d carry=%b run=%b model secs=%0d, want tens=%0d ones=%0d carry=%b run=%b",
               name, Tens, Ones, Carry, Running, m_secs, et, eo, ec, er);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      Tick = 1'b1; step();
      Tick = 1'b0; step();
    end
  endtask

  task automatic pulse_ss();
    StartStop = 1'b1; step();
    StartStop = 1'b0; step(); step();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin ss_h[i] = 1'b0; cl_h[i] = 1'b0; end
    #2;
    step(); step();
    lit("reset", 0, 0, 1'b0, 1'b0);
    Reset = 1'b0;
    step();

    pulse_ss();
    tick_n(12);
    lit("run12", 1, 2, 1'b0, 1'b1);

    tick_n(47);
    lit("at59", 5, 9, 1'b0, 1'b1);
    Tick = 1'b1; step(); Tick = 1'b0;
    lit("wrap", 0, 0, 1'b1, 1'b1);
    step();
    lit("carry_one_cycle", 0, 0, 1'b0, 1'b1);

    tick_n(7);
    pulse_ss();
    tick_n(5);
    lit("pause07", 0, 7, 1'b0, 1'b0);

    pulse_ss();
    tick_n(27);
    pulse_ss();
    lit("pause34", 3, 4, 1'b0, 1'b0);
    Clear = 1'b1; StartStop = 1'b1; step();
    Clear = 1'b0; StartStop = 1'b0; step(); step();
    lit("clear_beats_ss", 0, 0, 1'b0, 1'b0);
    tick_n(2);
    lit("idle_ignores_tick", 0, 0, 1'b0, 1'b0);

    pulse_ss();
    tick_n(20);
    lit("run20", 2, 0, 1'b0, 1'b1);
    StartStop = 1'b1; step();
    StartStop = 1'b0; step();
    Tick = 1'b1; step(); Tick = 1'b0;
    lit("tick_ss_run", 2, 1, 1'b0, 1'b0);
    StartStop = 1'b1; step();
    StartStop = 1'b0; step();
    Tick = 1'b1; step(); Tick = 1'b0;
    lit("tick_ss_pause", 2, 1, 1'b0, 1'b1);
    tick_n(1);
    lit("resumed22", 2, 2, 1'b0, 1'b1);

    StartStop = 1'b1; Reset = 1'b1; step(); step();
    lit("reset_mid_count", 0, 0, 1'b0, 1'b0);
    Reset = 1'b0; step(); step();
    lit("held_not_yet", 0, 0, 1'b0, 1'b0);
    step();
    lit("held_edge_after_reset", 0, 0, 1'b0, 1'b1);
    StartStop = 1'b0; step();

    tick_n(3);
    lit("run03", 0, 3, 1'b0, 1'b1);
    Clear = 1'b1; step();
    Clear = 1'b0; step();
    Tick = 1'b1; step(); Tick = 1'b0;
    lit("clear_beats_tick", 0, 0, 1'b0, 1'b0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
